// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch bus: request/address out of the fetch unit,
// acknowledge/data back from instruction memory.
interface pc_fetch_unit_if;
  logic        ImemReq;
  logic [63:0] ImemAddr;
  logic        ImemAck;
  logic [31:0] ImemData;

  // Fetch unit side: issues requests, receives instruction words.
  modport master (
    output ImemReq,
    output ImemAddr,
    input  ImemAck,
    input  ImemData
  );

  // Instruction memory side.
  modport slave (
    input  ImemReq,
    input  ImemAddr,
    output ImemAck,
    output ImemData
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program-counter register and instruction-fetch sequencer.
// Holds CurrentPC, fetches the instruction at CurrentPC over a req/ack bus,
// presents it to decode, and loads NextPC when the datapath commits.
// A fetch that sees no ack within IMEM_TIMEOUT cycles is dropped for one
// cycle and reissued at the same address.
// Optional feature: define MISALIGN_TRAP_EN to trap on a committed NextPC
// that is not word aligned (adds the Fault port and a terminal FAULT state).
module pc_fetch_unit #(
  parameter logic [63:0] RESET_PC     = 64'h0,
  parameter int          IMEM_TIMEOUT = 16
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [63:0]            NextPC,
  input  logic                   InstrDone,
  input  logic                   Stall,
  pc_fetch_unit_if.master        imem,
  output logic [63:0]            CurrentPC,
  output logic [31:0]            Instruction,
  output logic                   InstrValid,
  output logic                   FetchTimeout
`ifdef MISALIGN_TRAP_EN
  ,
  output logic                   Fault
`endif
);

  localparam int            CW       = $clog2(IMEM_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(IMEM_TIMEOUT - 1);

`ifdef MISALIGN_TRAP_EN
  typedef enum logic [1:0] {FETCH_IDLE, FETCH_WAIT, EXEC, FAULT} state_t;
`else
  typedef enum logic [1:0] {FETCH_IDLE, FETCH_WAIT, EXEC} state_t;
`endif

  state_t        state;
  logic [CW-1:0] wait_cnt;

  // Fetch sequencer: every output is a register updated on the rising edge.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    FetchTimeout <= 1'b0;
    if (Reset) begin
      // NOTE: reset is synchronous and wins over any fetch in progress; the
      // address register is reset too so ImemAddr is never X on the bus.
      state         <= FETCH_IDLE;
      CurrentPC     <= RESET_PC;
      Instruction   <= '0;
      InstrValid    <= 1'b0;
      imem.ImemReq  <= 1'b0;
      imem.ImemAddr <= RESET_PC;
      wait_cnt      <= '0;
`ifdef MISALIGN_TRAP_EN
      Fault         <= 1'b0;
`endif
    end else begin
      unique case (state)
        FETCH_IDLE: begin
          if (!Stall) begin
            imem.ImemReq  <= 1'b1;
            imem.ImemAddr <= CurrentPC;
            wait_cnt      <= '0;
            state         <= FETCH_WAIT;
          end
        end

        FETCH_WAIT: begin
          // Ack takes priority over an expiring timeout in the same cycle.
          if (imem.ImemAck) begin
            Instruction  <= imem.ImemData;
            InstrValid   <= 1'b1;
            imem.ImemReq <= 1'b0;
            wait_cnt     <= '0;
            state        <= EXEC;
          end else if (wait_cnt == CNT_LAST) begin
            imem.ImemReq <= 1'b0;
            FetchTimeout <= 1'b1;
            wait_cnt     <= '0;
            state        <= FETCH_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        EXEC: begin
          // Stall holds the instruction even when the datapath reports done.
          if (InstrDone && !Stall) begin
            CurrentPC  <= NextPC;
            InstrValid <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            if (NextPC[1:0] != 2'b00) begin
              Fault <= 1'b1;
              state <= FAULT;
            end else begin
              state <= FETCH_IDLE;
            end
`else
            state      <= FETCH_IDLE;
`endif
          end
        end

`ifdef MISALIGN_TRAP_EN
        // Terminal until reset: no fetches, nothing presented to decode.
        FAULT: begin
          imem.ImemReq <= 1'b0;
          InstrValid   <= 1'b0;
        end
`endif

        default: state <= FETCH_IDLE;
      endcase
    end
  end

endmodule
